// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage buffer and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances by one per qualifying cycle, sticks at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = PIPE_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: main + skid register pair with registered in_ready,
// flush to empty, and saturating stall/flush performance counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_vld, skid_vld;
  logic             in_fire, out_fire;

  // Valid bits are the state decode, so outputs stay purely registered.
  assign main_vld  = (state_q != ST_EMPTY);
  assign skid_vld  = (state_q == ST_FULL);
  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_buf;

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 16;
  localparam int unsigned CW_S = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic            in_ready_s, out_valid_s;
  logic [W-1:0]    out_data_s;
  logic [CW_S-1:0] stall_cnt_s, flush_cnt_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_buf #(.WIDTH(W), .CNT_W(CW_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  // Reference model: a FIFO of at most two payloads plus raw event counts.
  logic [W-1:0] q[$];
  int           stall_m = 0;
  int           flush_m = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      stall_m = 0;
      flush_m = 0;
    end else begin
      automatic bit can_take = (q.size() < 2);
      automatic bit has_out  = (q.size() > 0);
      automatic bit tk = in_valid && can_take;
      automatic bit gv = has_out && out_ready;
      if (has_out && !out_ready) stall_m++;
      if (flush) flush_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (gv) void'(q.pop_front());
        if (tk) q.push_back(in_data);
      end
    end
  end

  function automatic int sat(int v, int unsigned w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic logic [W-1:0] exp_d = (q.size() > 0) ? q[0] : '0;
    chk("m_out_valid", out_valid, q.size() > 0);
    chk("m_in_ready", in_ready, q.size() < 2);
    chk("m_out_data", out_data, exp_d);
    chk("m_stall_cnt", stall_cnt, sat(stall_m, CW));
    chk("m_flush_cnt", flush_cnt, sat(flush_m, CW));
    chk("m_out_data_s", out_data_s, exp_d);
    chk("m_stall_cnt_s", stall_cnt_s, sat(stall_m, CW_S));
    chk("m_flush_cnt_s", flush_cnt_s, sat(flush_m, CW_S));
  end

  // Drive one cycle's inputs at the current negedge and advance one cycle.
  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full rate
    cyc(1, 32'h11, 1, 0); chk("s1_data", out_data, 32'h11); chk("s1_rdy", in_ready, 1);
    cyc(1, 32'h22, 1, 0); chk("s2_data", out_data, 32'h22); chk("s2_rdy", in_ready, 1);
    cyc(1, 32'h33, 1, 0); chk("s3_data", out_data, 32'h33); chk("s3_rdy", in_ready, 1);
    cyc(0, 32'h0, 1, 0);  chk("s_empty_v", out_valid, 0); chk("s_empty_d", out_data, 0);
    chk("s_stall", stall_cnt, 0);

    // Skid fill and drain
    cyc(1, 32'hA, 0, 0); chk("k_main", out_data, 32'hA);
    cyc(1, 32'hB, 0, 0); chk("k_full_rdy", in_ready, 0); chk("k_hold", out_data, 32'hA);
    cyc(1, 32'hC, 0, 0); chk("k_full_rdy2", in_ready, 0);
    cyc(1, 32'hC, 1, 0); chk("k_d1", out_data, 32'hB); chk("k_rdy_back", in_ready, 1);
    cyc(1, 32'hC, 1, 0); chk("k_d2", out_data, 32'hC);
    cyc(0, 32'h0, 1, 0); chk("k_empty", out_valid, 0);
    chk("k_stall", stall_cnt, 2);

    // Flush while FULL, then flush colliding with an accept
    cyc(1, 32'hA, 0, 0);
    cyc(1, 32'hB, 0, 0); chk("f_full", in_ready, 0);
    cyc(0, 32'h0, 0, 1);
    chk("f_v", out_valid, 0); chk("f_d", out_data, 0); chk("f_rdy", in_ready, 1);
    chk("f_cnt", flush_cnt, 1); chk("f_stall", stall_cnt, 4);
    cyc(1, 32'h55, 0, 1); chk("f2_v", out_valid, 0); chk("f2_cnt", flush_cnt, 2);
    cyc(0, 32'h0, 1, 0);  chk("f3_v", out_valid, 0); chk("f3_d", out_data, 0);

    // Asynchronous reset between edges while FULL
    cyc(1, 32'h1, 0, 0);
    cyc(1, 32'h2, 0, 0); chk("a_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("a_v", out_valid, 0); chk("a_rdy", in_ready, 1); chk("a_d", out_data, 0);
    chk("a_stall", stall_cnt, 0); chk("a_flush", flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the narrow counter
    cyc(1, 32'h7, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 32'h0, 0, 0);
    chk("sat_small", stall_cnt_s, 15);
    chk("sat_wide", stall_cnt, 20);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0); chk("sat_hold", stall_cnt_s, 15);

    // Randomized traffic with varying backpressure
    for (int i = 0; i < 3000; i++) begin
      automatic int unsigned rp = (i / 250) % 4;
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) >= rp,
          $urandom_range(0, 31) == 0);
    end
    cyc(0, 32'h0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
